// File: rtl/inbuf_pkg.sv
// Shared types and width helpers for the input staging buffer.
// Optional feature macro: INBUF_OVF_DETECT_EN (sticky overflow flag).
package inbuf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  // Default geometry; modules derive their own widths from their parameters.
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_SCR_DEPTH = 4;
  localparam int DEF_LVL_W     = $clog2(DEF_DEPTH + 1);
  localparam int DEF_PTR_W     = $clog2(DEF_DEPTH);
  localparam int DEF_CNT_W     = $clog2(DEF_SCR_DEPTH);

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer/address width; floor of 1 so a depth of 1 still gets a real bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/inbuf_word_fifo.sv
// Width-converting word FIFO: PW words in per push, PR words out per pop.
// Macro INBUF_OVF_DETECT_EN does not affect this module.
module inbuf_word_fifo
  import inbuf_pkg::*;
#(
  parameter int DW    = 16,
  parameter int PW    = 1,
  parameter int PR    = 1,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      clear_i,
  input  logic                      wen_i,
  input  logic [PW*DW-1:0]          din_i,
  input  logic                      pop_i,
  output logic [PR*DW-1:0]          dout_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [lvl_w(DEPTH)-1:0]   level_o
);

  localparam int LVL_W = lvl_w(DEPTH);
  localparam int PTR_W = ptr_w(DEPTH);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push;

  // Flags look at the pre-edge level, so a same-cycle pop never makes room.
  assign full_o  = level_q > LVL_W'(DEPTH - PW);
  assign empty_o = level_q < LVL_W'(PR);
  assign level_o = level_q;
  assign push    = wen_i && !full_o;

  always_comb begin
    level_d = level_q;
    if (push)  level_d = level_d + LVL_W'(PW);
    if (pop_i) level_d = level_d - LVL_W'(PR);
  end

  always_comb begin
    dout_o = '0;
    for (int i = 0; i < PR; i++)
      dout_o[i*DW +: DW] = mem_q[rptr_q + PTR_W'(i)];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        for (int i = 0; i < PW; i++)
          mem_q[wptr_q + PTR_W'(i)] <= din_i[i*DW +: DW];
        wptr_q <= wptr_q + PTR_W'(PW);
      end
      if (pop_i) rptr_q <= rptr_q + PTR_W'(PR);
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/input_buffer_stream_ctrl.sv
// Input staging buffer: word FIFO plus a length-programmable scratchpad transfer FSM.
// Macro INBUF_OVF_DETECT_EN enables the sticky ovf_err flag on dropped beats.
module input_buffer_stream_ctrl
  import inbuf_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int PAR_WRITE     = 1,
  parameter int PAR_READ      = 1,
  parameter int DEPTH         = 8,
  parameter int SCRATCH_DEPTH = 4,
  parameter int LEN_W         = 8
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            clear,
  input  logic                            start,
  input  logic [LEN_W-1:0]                len,
  input  logic                            wen,
  input  logic [PAR_WRITE*DATA_WIDTH-1:0] din,
  output logic                            full,
  output logic                            empty,
  output logic [lvl_w(DEPTH)-1:0]         level,
  input  logic                            scratch_write_en,
  output logic                            write_in_scratch,
  output logic [PAR_READ*DATA_WIDTH-1:0]  dout,
  output logic [ptr_w(SCRATCH_DEPTH)-1:0] cnt,
  output logic                            busy,
  output logic                            done,
  output logic                            ovf_err
);

  localparam int CNT_W = ptr_w(SCRATCH_DEPTH);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  inbuf_word_fifo #(
    .DW(DATA_WIDTH), .PW(PAR_WRITE), .PR(PAR_READ), .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .clear_i (clear),
    .wen_i   (wen),
    .din_i   (din),
    .pop_i   (write_in_scratch),
    .dout_o  (dout),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (len == '0) ? DONE : XFER;
      XFER:    if (write_in_scratch && rem_q == LEN_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  always_comb begin
    busy             = (state_q == XFER);
    done             = (state_q == DONE);
    write_in_scratch = busy && !empty && scratch_write_en;
  end

  // cnt survives clear so the scratchpad address keeps its position.
  always_comb begin
    rem_d = rem_q;
    cnt_d = cnt_q;
    if (!clear) begin
      if (state_q == IDLE && start) begin
        rem_d = len;
        cnt_d = '0;
      end else if (write_in_scratch) begin
        rem_d = rem_q - LEN_W'(1);
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rem_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

`ifdef INBUF_OVF_DETECT_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q | (wen && full);
    if (clear) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf_err = ovf_q;
`else
  assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_input_buffer_stream_ctrl.sv
// Self-checking bench: directed test-plan steps then random traffic against a queue-based model.
module tb_input_buffer_stream_ctrl;
  localparam int DW = 16, PW = 2, PR = 1, DEPTH = 8, SD = 4, LW = 8;
`ifdef INBUF_OVF_DETECT_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn, clear, start, wen, swe;
  logic [LW-1:0] len;
  logic [PW*DW-1:0] din;
  logic          full, empty, wis, busy, done, ovf_err;
  logic [3:0]    level;
  logic [PR*DW-1:0] dout;
  logic [1:0]    cnt;

  input_buffer_stream_ctrl #(
    .DATA_WIDTH(DW), .PAR_WRITE(PW), .PAR_READ(PR), .DEPTH(DEPTH),
    .SCRATCH_DEPTH(SD), .LEN_W(LW)
  ) dut (
    .clk(clk), .rstn(rstn), .clear(clear), .start(start), .len(len),
    .wen(wen), .din(din), .full(full), .empty(empty), .level(level),
    .scratch_write_en(swe), .write_in_scratch(wis), .dout(dout),
    .cnt(cnt), .busy(busy), .done(done), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  // Reference model: word queue plus job bookkeeping (phase 0 idle, 1 moving, 2 finishing).
  int unsigned mq[$];
  int mph, mrem, mcnt;
  bit movf, ewis;
  int checks = 0, failures = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mph = 0; mrem = 0; mcnt = 0; movf = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_full", 32'(full), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_level", 32'(level), 0);
    chk("rst_wis", 32'(wis), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovf", 32'(ovf_err), 0);
  endtask

  // Check outputs mid-cycle, then advance the model across the rising edge.
  task automatic tick();
    int pre;
    @(negedge clk);
    pre  = mq.size();
    ewis = (mph == 1) && (pre >= PR) && swe;
    chk("level", 32'(level), 32'(pre));
    chk("full", 32'(full), 32'((DEPTH - pre) < PW));
    chk("empty", 32'(empty), 32'(pre < PR));
    chk("wis", 32'(wis), 32'(ewis));
    chk("busy", 32'(busy), 32'(mph == 1));
    chk("done", 32'(done), 32'(mph == 2));
    chk("cnt", 32'(cnt), 32'(mcnt));
    chk("ovf", 32'(ovf_err), 32'(movf));
    if (ewis) chk("dout", 32'(dout), mq[0]);
    @(posedge clk);
    cyc++;
    if (clear) begin
      mq.delete(); mph = 0; movf = 1'b0;
    end else begin
      case (mph)
        0: if (start) begin
             mrem = int'(len); mcnt = 0;
             mph = (len == 0) ? 2 : 1;
           end
        1: if (ewis) begin
             void'(mq.pop_front());
             mcnt = (mcnt + 1) % SD;
             mrem--;
             if (mrem == 0) mph = 2;
           end
        default: mph = 0;
      endcase
      if (wen) begin
        if (pre <= DEPTH - PW) begin
          for (int w = 0; w < PW; w++) mq.push_back(int'(din[w*DW +: DW]));
        end else if (OVF_ON) movf = 1'b1;
      end
    end
    #1;
  endtask

  task automatic fill4(input int base);
    for (int b = 0; b < 4; b++) begin
      wen = 1'b1;
      din = {16'(base + 2*b + 1), 16'(base + 2*b)};
      tick();
    end
    wen = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; clear = 1'b0; start = 1'b0; wen = 1'b0; swe = 1'b0;
    len = '0; din = '0;
    model_reset();
    #12;
    chk_reset_outputs();
    @(posedge clk); #1;
    rstn = 1'b1;
    tick();

    // Fill with words 1..8, then a dropped fifth beat.
    fill4(1);
    wen = 1'b1; din = 32'hDEAD_BEEF; tick(); wen = 1'b0;
    chk("full_after_fill", 32'(level), 8);
    tick();

    // len=8 with scratch always ready.
    swe = 1'b1; start = 1'b1; len = 8'd8; tick(); start = 1'b0;
    repeat (11) tick();

    // Same job with scratch ready only on alternate cycles.
    fill4(101);
    start = 1'b1; len = 8'd8; tick(); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      swe = i[0];
      tick();
    end
    swe = 1'b1;

    // Zero-length job: immediate done, FIFO untouched.
    fill4(201);
    start = 1'b1; len = 8'd0; tick(); start = 1'b0;
    repeat (3) tick();
    chk("len0_level", 32'(level), 8);

    // Clear during the third write of a len=8 job.
    start = 1'b1; len = 8'd8; tick(); start = 1'b0;
    tick(); tick();
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_level", 32'(level), 0);
    chk("clr_busy", 32'(busy), 0);
    chk("clr_done", 32'(done), 0);
    repeat (3) tick();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      wen   = 1'($urandom_range(0, 1));
      din   = $urandom;
      swe   = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 5) == 0);
      len   = 8'($urandom_range(0, 11));
      clear = ($urandom_range(0, 39) == 0);
      tick();
    end
    clear = 1'b0; start = 1'b0; wen = 1'b0;

    // Reset in the middle of a transfer.
    clear = 1'b1; tick(); clear = 1'b0;
    wen = 1'b1; din = $urandom; swe = 1'b1;
    start = 1'b1; len = 8'd20; tick(); start = 1'b0;
    tick(); tick();
    chk("pre_rst_busy", 32'(busy), 1);
    rstn = 1'b0; wen = 1'b0;
    #1;
    model_reset();
    chk_reset_outputs();
    @(posedge clk); #1;
    chk_reset_outputs();
    rstn = 1'b1;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
